// File: rtl/ahb_slave_interface.sv
// AHB-side front end of the AHB-to-APB bridge: transfer qualification, slave decode, pipelining.
// Optional AHB ERROR response and alignment checks are compiled in with `define AHB_ERR_RESP_EN.
module ahb_slave_interface #(
  parameter logic [31:0] SLV0_BASE = 32'h8000_0000,
  parameter logic [31:0] SLV1_BASE = 32'h8400_0000,
  parameter logic [31:0] SLV2_BASE = 32'h8800_0000,
  parameter logic [31:0] SLV_SIZE  = 32'h0400_0000
) (
  input  logic        Hclk,
  input  logic        Hreset,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [2:0]  Hsize,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Prdata,
  output logic        valid,
  output logic [2:0]  tempselx,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [31:0] Hwdata2,
  output logic        Hwritereg,
  output logic [31:0] Hrdata,
  output logic [1:0]  Hresp,
  output logic        Herr_stall
);

  logic [31:0] r_haddr1, r_haddr2, r_hwdata1, r_hwdata2;
  logic        r_hwritereg;
  logic [31:0] w_off0, w_off1, w_off2;
  logic        w_unmapped, w_dec_err, w_fsm_okay, w_active;
  logic        w_unused;

  // Unsigned wrap-around makes one compare cover both window bounds.
  assign w_off0 = Haddr - SLV0_BASE;
  assign w_off1 = Haddr - SLV1_BASE;
  assign w_off2 = Haddr - SLV2_BASE;

  always_comb begin
    tempselx = 3'b000;
    if (w_off0 < SLV_SIZE)      tempselx = 3'b001;
    else if (w_off1 < SLV_SIZE) tempselx = 3'b010;
    else if (w_off2 < SLV_SIZE) tempselx = 3'b100;
  end

  assign w_unmapped = (tempselx == 3'b000);
  assign w_active   = Hreadyin & Htrans[1];

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_haddr1    <= '0;
      r_haddr2    <= '0;
      r_hwdata1   <= '0;
      r_hwdata2   <= '0;
      r_hwritereg <= 1'b0;
    end else begin
      r_haddr1    <= Haddr;
      r_haddr2    <= r_haddr1;
      r_hwdata1   <= Hwdata;
      r_hwdata2   <= r_hwdata1;
      r_hwritereg <= Hwrite;
    end
  end

`ifdef AHB_ERR_RESP_EN
  typedef enum logic [1:0] {StOkay, StErr1, StErr2} err_state_e;

  err_state_e r_state;
  logic [1:0] r_hresp;
  logic       r_herr_stall;
  logic       w_misalign;

  assign w_misalign = (Hsize > 3'd2) |
                      ((Hsize == 3'd1) & Haddr[0]) |
                      ((Hsize == 3'd2) & (Haddr[1:0] != 2'b00));
  assign w_dec_err  = w_unmapped | w_misalign;
  assign w_fsm_okay = (r_state == StOkay);

  // Two-cycle ERROR: first cycle stalls HREADYOUT, second completes the response.
  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      r_state      <= StOkay;
      r_hresp      <= 2'b00;
      r_herr_stall <= 1'b0;
    end else begin
      unique case (r_state)
        StOkay: begin
          if (w_active & w_dec_err) begin
            r_state      <= StErr1;
            r_hresp      <= 2'b01;
            r_herr_stall <= 1'b1;
          end else begin
            r_hresp      <= 2'b00;
            r_herr_stall <= 1'b0;
          end
        end
        StErr1: begin
          r_state      <= StErr2;
          r_hresp      <= 2'b01;
          r_herr_stall <= 1'b0;
        end
        StErr2: begin
          r_state      <= StOkay;
          r_hresp      <= 2'b00;
          r_herr_stall <= 1'b0;
        end
        default: begin
          r_state      <= StOkay;
          r_hresp      <= 2'b00;
          r_herr_stall <= 1'b0;
        end
      endcase
    end
  end

  assign Hresp      = r_hresp;
  assign Herr_stall = r_herr_stall;
  assign w_unused   = Htrans[0];
`else
  // Unmapped transfers are dropped silently with an OKAY response.
  assign w_dec_err  = w_unmapped;
  assign w_fsm_okay = 1'b1;
  assign Hresp      = 2'b00;
  assign Herr_stall = 1'b0;
  assign w_unused   = Htrans[0] ^ (^Hsize);
`endif

  assign valid     = w_active & ~w_unmapped & ~w_dec_err & w_fsm_okay;
  assign Haddr1    = r_haddr1;
  assign Haddr2    = r_haddr2;
  assign Hwdata1   = r_hwdata1;
  assign Hwdata2   = r_hwdata2;
  assign Hwritereg = r_hwritereg;
  assign Hrdata    = Prdata;

endmodule

// File: tb/tb_ahb_slave_interface.sv
// Directed bench for ahb_slave_interface; error-response expectations follow AHB_ERR_RESP_EN.
module tb_ahb_slave_interface;

  logic        Hclk = 1'b0;
  logic        Hreset, Hwrite, Hreadyin;
  logic [1:0]  Htrans;
  logic [2:0]  Hsize;
  logic [31:0] Haddr, Hwdata, Prdata;
  logic        valid, Hwritereg, Herr_stall;
  logic [2:0]  tempselx;
  logic [31:0] Haddr1, Haddr2, Hwdata1, Hwdata2, Hrdata;
  logic [1:0]  Hresp;

  int errs = 0;
  int checks = 0;

  ahb_slave_interface dut (
    .Hclk(Hclk), .Hreset(Hreset), .Hwrite(Hwrite), .Hreadyin(Hreadyin), .Htrans(Htrans),
    .Hsize(Hsize), .Haddr(Haddr), .Hwdata(Hwdata), .Prdata(Prdata), .valid(valid),
    .tempselx(tempselx), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
    .Hwdata2(Hwdata2), .Hwritereg(Hwritereg), .Hrdata(Hrdata), .Hresp(Hresp),
    .Herr_stall(Herr_stall)
  );

  always #5 Hclk = ~Hclk;

  // Inputs change just after a negedge; the following posedge captures them.
  task automatic nxt();
    @(negedge Hclk);
  endtask

  task automatic drive(input logic [1:0] tr, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd);
    Htrans = tr; Hwrite = wr; Haddr = a; Hwdata = wd; #1;
  endtask

  task automatic test_reset();
    Hreset = 1'b1; Hreadyin = 1'b1; Hsize = 3'd2; Prdata = '0;
    drive(2'b10, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D);
    nxt(); nxt();
    Hreset = 1'b0; drive(2'b00, 1'b0, 32'h0, 32'h0);
    checks++; if (Haddr1 !== 32'h0 || Haddr2 !== 32'h0) begin errs++;
      $display("FAIL reset_haddr: got %h/%h expected 0/0", Haddr1, Haddr2); end
    checks++; if (Hwdata1 !== 32'h0 || Hwdata2 !== 32'h0) begin errs++;
      $display("FAIL reset_hwdata: got %h/%h expected 0/0", Hwdata1, Hwdata2); end
    checks++; if (Hwritereg !== 1'b0 || Hresp !== 2'b00 || Herr_stall !== 1'b0) begin errs++;
      $display("FAIL reset_ctrl: got wr=%b resp=%b stall=%b expected 0/00/0",
               Hwritereg, Hresp, Herr_stall); end
    nxt();
  endtask

  task automatic test_single_write();
    drive(2'b10, 1'b1, 32'h8000_0010, 32'h0);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b001) begin errs++;
      $display("FAIL write_addr: got valid=%b sel=%b expected 1/001", valid, tempselx); end
    nxt();
    drive(2'b00, 1'b0, 32'h0, 32'hA5A5_0001);
    checks++; if (Haddr1 !== 32'h8000_0010 || Hwritereg !== 1'b1) begin errs++;
      $display("FAIL write_pipe1: got %h wr=%b expected 80000010 wr=1", Haddr1, Hwritereg); end
    nxt();
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    checks++; if (Hwdata1 !== 32'hA5A5_0001 || Haddr2 !== 32'h8000_0010) begin errs++;
      $display("FAIL write_pipe2: got wd1=%h a2=%h expected a5a50001/80000010",
               Hwdata1, Haddr2); end
    nxt();
  endtask

  task automatic test_single_read();
    Prdata = 32'h1234_5678;
    drive(2'b10, 1'b0, 32'h8400_0004, 32'h0);
    checks++; if (valid !== 1'b1 || tempselx !== 3'b010 || Hrdata !== 32'h1234_5678) begin
      errs++; $display("FAIL read: got valid=%b sel=%b rdata=%h expected 1/010/12345678",
                       valid, tempselx, Hrdata); end
    nxt();
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    checks++; if (Hwritereg !== 1'b0) begin errs++;
      $display("FAIL read_dir: got %b expected 0", Hwritereg); end
    nxt();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [4];
    for (int j = 0; j < 4; j++) a[j] = 32'h8800_0000 + 32'(j * 4);
    for (int j = 0; j < 6; j++) begin
      if (j < 4) drive((j == 0) ? 2'b10 : 2'b11, 1'b1, a[j], 32'h1000 + 32'(j));
      else drive(2'b00, 1'b0, 32'h0, 32'h0);
      if (j < 4) begin
        checks++; if (valid !== 1'b1 || tempselx !== 3'b100) begin errs++;
          $display("FAIL burst_valid[%0d]: got %b/%b expected 1/100", j, valid, tempselx); end
      end
      if (j >= 2) begin
        checks++; if (Haddr2 !== a[j-2]) begin errs++;
          $display("FAIL burst_haddr2[%0d]: got %h expected %h", j, Haddr2, a[j-2]); end
      end
      nxt();
    end
  endtask

  task automatic test_qualification();
    for (int j = 0; j < 3; j++) begin
      Hreadyin = (j == 2) ? 1'b0 : 1'b1;
      drive((j == 0) ? 2'b00 : ((j == 1) ? 2'b01 : 2'b10), 1'b1, 32'h8000_0000, 32'h0);
      checks++; if (valid !== 1'b0 || tempselx !== 3'b001) begin errs++;
        $display("FAIL qual[%0d]: got valid=%b sel=%b expected 0/001", j, valid, tempselx); end
      nxt();
    end
    Hreadyin = 1'b1; drive(2'b00, 1'b0, 32'h0, 32'h0); nxt();
  endtask

  task automatic test_error();
    logic [31:0] ea [2];
    ea[0] = 32'h9000_0000; ea[1] = 32'h8000_0002;
    for (int k = 0; k < 2; k++) begin
      drive(2'b10, 1'b0, ea[k], 32'h0);
      if (k == 0) begin
        checks++; if (valid !== 1'b0 || tempselx !== 3'b000) begin errs++;
          $display("FAIL err_addr[%0d]: got valid=%b sel=%b expected 0/000", k, valid, tempselx);
        end
      end
`ifdef AHB_ERR_RESP_EN
      else begin
        checks++; if (valid !== 1'b0 || tempselx !== 3'b001) begin errs++;
          $display("FAIL err_addr[%0d]: got valid=%b sel=%b expected 0/001", k, valid, tempselx);
        end
      end
`endif
      nxt();
      // A mapped NONSEQ during ERR1 must be ignored.
      drive(2'b10, 1'b0, 32'h8000_0000, 32'h0);
`ifdef AHB_ERR_RESP_EN
      checks++; if (Hresp !== 2'b01 || Herr_stall !== 1'b1 || valid !== 1'b0) begin errs++;
        $display("FAIL err1[%0d]: got resp=%b stall=%b valid=%b expected 01/1/0",
                 k, Hresp, Herr_stall, valid); end
      nxt(); drive(2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (Hresp !== 2'b01 || Herr_stall !== 1'b0 || valid !== 1'b0) begin errs++;
        $display("FAIL err2[%0d]: got resp=%b stall=%b valid=%b expected 01/0/0",
                 k, Hresp, Herr_stall, valid); end
      nxt(); drive(2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (Hresp !== 2'b00 || Herr_stall !== 1'b0) begin errs++;
        $display("FAIL err_done[%0d]: got resp=%b stall=%b expected 00/0", k, Hresp, Herr_stall);
      end
`else
      checks++; if (Hresp !== 2'b00 || Herr_stall !== 1'b0 || valid !== 1'b1) begin errs++;
        $display("FAIL noerr[%0d]: got resp=%b stall=%b valid=%b expected 00/0/1",
                 k, Hresp, Herr_stall, valid); end
      nxt(); drive(2'b00, 1'b0, 32'h0, 32'h0);
      checks++; if (Hresp !== 2'b00 || Herr_stall !== 1'b0) begin errs++;
        $display("FAIL noerr2[%0d]: got resp=%b stall=%b expected 00/0", k, Hresp, Herr_stall);
      end
      nxt(); drive(2'b00, 1'b0, 32'h0, 32'h0);
`endif
      nxt();
    end
  endtask

  task automatic test_reset_mid_burst();
    drive(2'b10, 1'b1, 32'h8800_0000, 32'h0);   nxt();
    drive(2'b11, 1'b1, 32'h8800_0004, 32'h11);  nxt();
    Hreset = 1'b1;
    drive(2'b11, 1'b1, 32'h8800_0008, 32'h22);  nxt();
    Hreset = 1'b0;
    drive(2'b10, 1'b1, 32'h8800_0008, 32'h33);
    checks++; if (Haddr1 !== 32'h0 || Haddr2 !== 32'h0 || Hwdata1 !== 32'h0 ||
                  Hwdata2 !== 32'h0 || Hwritereg !== 1'b0) begin errs++;
      $display("FAIL rst_mid_pipe: got %h %h %h %h %b expected all 0",
               Haddr1, Haddr2, Hwdata1, Hwdata2, Hwritereg); end
    checks++; if (Hresp !== 2'b00 || Herr_stall !== 1'b0) begin errs++;
      $display("FAIL rst_mid_resp: got %b/%b expected 00/0", Hresp, Herr_stall); end
    checks++; if (valid !== 1'b1 || tempselx !== 3'b100) begin errs++;
      $display("FAIL rst_mid_resume: got valid=%b sel=%b expected 1/100", valid, tempselx); end
    nxt();
    drive(2'b00, 1'b0, 32'h0, 32'h0);
    checks++; if (Haddr1 !== 32'h8800_0008 || Hwritereg !== 1'b1) begin errs++;
      $display("FAIL rst_mid_after: got %h wr=%b expected 88000008 wr=1", Haddr1, Hwritereg); end
    nxt();
  endtask

  initial begin
    Hreset = 1'b1; Hwrite = 1'b0; Hreadyin = 1'b1; Htrans = 2'b00; Hsize = 3'd2;
    Haddr = '0; Hwdata = '0; Prdata = '0;
    nxt();
    test_reset();
    test_single_write();
    test_single_read();
    test_back_to_back();
    test_qualification();
    test_error();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
